gelato_decode: RTL and testbench
================================

Name: gelato_decode

Overview:
Decode stage for the Gelato SIMT core. It accepts raw 32-bit RV32 instruction words tagged with warp number and PC from the fetch stage, and produces the unpacked instruction fields (opcode, rd, rs1, rs2, rs3, imm, funct3, funct7) plus an illegal flag for issue/scoreboard. A 2-entry skid buffer gives registered valid/ready handshakes on both sides, so neither side sees a combinational ready path.

Parameters:
WARP_NUM_WIDTH, 5, width of the warp tag (32 warps)
ADDR_WIDTH, 32, PC width
DATA_WIDTH, 32, raw instruction and imm width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of buffered entries
in_valid  in  1  fetch word valid
in_ready  out  1  decode can accept; registered, equals !full
in_warp  in  WARP_NUM_WIDTH  warp tag
in_pc  in  ADDR_WIDTH  instruction PC
in_inst  in  32  raw instruction word
out_valid  out  1  decoded entry available (head of buffer)
out_ready  in  1  issue accepts
out_warp  out  WARP_NUM_WIDTH  warp tag of head
out_pc  out  ADDR_WIDTH  PC of head
out_opcode  out  7  inst[6:0]
out_rd  out  5  destination register
out_rs1  out  5  source 1
out_rs2  out  5  source 2
out_rs3  out  5  source 3 (R4 only)
out_imm  out  32  sign-extended immediate
out_funct3  out  3  funct3
out_funct7  out  7  funct7
out_illegal  out  1  unrecognised encoding

Behaviour:
- Reset (rst_n low, async): buffer empty, count=0, rd/wr pointers 0; out_valid=0, in_ready=1; all data outputs 0.
- Decode is combinational on in_inst; the decoded result is written into the buffer on accept (in_valid & in_ready). Latency: accepted at edge N -> out_valid=1 from N+1 if buffer was empty.
- Buffer: 2 entries, circular, 1-bit pointers wrap 1->0. in_ready = (count!=2), registered. out_valid = (count!=0). Outputs are driven from the head entry.
- Simultaneous push and pop: count unchanged, both pointers advance. Push only: count+1. Pop only: count-1. Push when full is impossible (in_ready=0); pop when empty is ignored.
- Out-side hold: while out_valid & !out_ready, all out_* stay stable.
- flush: at the next edge count=0, pointers=0, out_valid=0, in_ready=1. A concurrent input is dropped. flush has priority over push and pop.
- Field rules by opcode (inst[6:0]):
  - I-type (0000011 load, 0000111 fp-load, 0010011 op-imm, 1100111 jalr, 1110011 system): rd, rs1, funct3 raw; rs2=rs3=0; funct7=0; imm=sext(inst[31:20]).
  - S (0100011, 0100111): rs1, rs2, funct3 raw; rd=0; imm=sext({inst[31:25],inst[11:7]}).
  - B (1100011): rs1, rs2, funct3 raw; rd=0; imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U (0110111, 0010111): rd raw; imm={inst[31:12],12'b0}; rs1, rs2, funct3, funct7 all 0.
  - J (1101111): rd raw; imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); other fields 0.
  - R (0110011, 1010011): rd, rs1, rs2, funct3, funct7 raw; imm=0.
  - R4 (1000011, 1000111, 1001011, 1001111): rd, rs1, rs2 raw; rs3=inst[31:27]; funct3 raw; funct7={5'b0,inst[26:25]}; imm=0.
  - Any other opcode: out_illegal=1; all fields 0 except out_opcode raw. The entry still flows through the handshake.
- Register fields sit at rd=[11:7], rs1=[19:15], rs2=[24:20].

Test Plan:
- Reset mid-stream: 2 entries buffered, pulse rst_n low -> out_valid=0, in_ready=1 immediately, all outputs 0.
- 0x00500093 (addi x1,x0,5), warp 3, pc 0x100, out_ready=1 -> next cycle out_valid=1, opcode 0x13, rd=1, rs1=0, imm=5, funct3=0, warp 3, pc 0x100.
- 0xFE20AE23 (sw x2,-4(x1)) -> rd=0, rs1=1, rs2=2, funct3=2, imm=0xFFFFFFFC; then 0xFE000CE3 (beq x0,x0,-8) -> imm=0xFFFFFFF8, rd=0.
- Backpressure: out_ready=0, push 3 words -> in_ready drops to 0 after the 2nd accept, 3rd held at source; raise out_ready -> order preserved, one output per cycle, no loss or duplication.
- Simultaneous push/pop with count=1 for 10 cycles -> count stays 1, in_ready stays 1, pointers wrap correctly.
- 0x0000007F -> out_illegal=1, opcode 0x7F, other fields 0; flush asserted with in_valid=1 while full -> next cycle empty, the input is dropped.

Source files
------------

// File: rtl/gelato_decode.sv
// rtl/gelato_decode.sv - RV32 decode stage with 2-entry skid buffer for the Gelato SIMT core
//
// Purpose: unpacks raw instruction words into issue fields and buffers the
// decoded result behind registered valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous clear of all buffered entries
//   in_valid/in_ready   fetch-side handshake; in_ready comes straight from count
//   in_warp/pc/inst     fetch word with its warp tag and PC
//   out_valid/out_ready issue-side handshake; out_* reflect the buffer head
//   out_opcode..funct7  decoded fields, out_imm sign-extended
//   out_illegal         opcode not recognised (entry still flows through)
module gelato_decode #(
   parameter int WARP_NUM_WIDTH = 5,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WARP_NUM_WIDTH-1:0] in_warp,
   input  logic [ADDR_WIDTH-1:0]     in_pc,
   input  logic [31:0]               in_inst,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WARP_NUM_WIDTH-1:0] out_warp,
   output logic [ADDR_WIDTH-1:0]     out_pc,
   output logic [6:0]                out_opcode,
   output logic [4:0]                out_rd,
   output logic [4:0]                out_rs1,
   output logic [4:0]                out_rs2,
   output logic [4:0]                out_rs3,
   output logic [DATA_WIDTH-1:0]     out_imm,
   output logic [2:0]                out_funct3,
   output logic [6:0]                out_funct7,
   output logic                      out_illegal
);

   typedef struct packed {
      logic [WARP_NUM_WIDTH-1:0] warp;
      logic [ADDR_WIDTH-1:0]     pc;
      logic [6:0]                opcode;
      logic [4:0]                rd;
      logic [4:0]                rs1;
      logic [4:0]                rs2;
      logic [4:0]                rs3;
      logic [DATA_WIDTH-1:0]     imm;
      logic [2:0]                funct3;
      logic [6:0]                funct7;
      logic                      illegal;
   } entry_t;

   entry_t     dec;
   entry_t     mem [2];
   logic [1:0] count;
   logic       wr_ptr;
   logic       rd_ptr;
   logic       push;
   logic       pop;
   logic [31:0] imm32;

   // Combinational decode of the incoming word
   always_comb begin
      dec         = '0;
      imm32       = '0;
      dec.warp    = in_warp;
      dec.pc      = in_pc;
      dec.opcode  = in_inst[6:0];
      case (in_inst[6:0])
         7'b0000011, 7'b0000111, 7'b0010011, 7'b1100111, 7'b1110011: begin
            dec.rd     = in_inst[11:7];
            dec.rs1    = in_inst[19:15];
            dec.funct3 = in_inst[14:12];
            imm32      = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         7'b0100011, 7'b0100111: begin
            dec.rs1    = in_inst[19:15];
            dec.rs2    = in_inst[24:20];
            dec.funct3 = in_inst[14:12];
            imm32      = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         end
         7'b1100011: begin
            dec.rs1    = in_inst[19:15];
            dec.rs2    = in_inst[24:20];
            dec.funct3 = in_inst[14:12];
            imm32      = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                          in_inst[30:25], in_inst[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec.rd = in_inst[11:7];
            imm32  = {in_inst[31:12], 12'b0};
         end
         7'b1101111: begin
            dec.rd = in_inst[11:7];
            imm32  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                      in_inst[20], in_inst[30:21], 1'b0};
         end
         7'b0110011, 7'b1010011: begin
            dec.rd     = in_inst[11:7];
            dec.rs1    = in_inst[19:15];
            dec.rs2    = in_inst[24:20];
            dec.funct3 = in_inst[14:12];
            dec.funct7 = in_inst[31:25];
         end
         7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
            dec.rd     = in_inst[11:7];
            dec.rs1    = in_inst[19:15];
            dec.rs2    = in_inst[24:20];
            dec.rs3    = in_inst[31:27];
            dec.funct3 = in_inst[14:12];
            dec.funct7 = {5'b0, in_inst[26:25]};
         end
         default: dec.illegal = 1'b1;
      endcase
      dec.imm = DATA_WIDTH'(signed'(imm32));
   end

   // count is a flop, so both ready and valid are register outputs
   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (flush) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= dec;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign out_warp    = mem[rd_ptr].warp;
   assign out_pc      = mem[rd_ptr].pc;
   assign out_opcode  = mem[rd_ptr].opcode;
   assign out_rd      = mem[rd_ptr].rd;
   assign out_rs1     = mem[rd_ptr].rs1;
   assign out_rs2     = mem[rd_ptr].rs2;
   assign out_rs3     = mem[rd_ptr].rs3;
   assign out_imm     = mem[rd_ptr].imm;
   assign out_funct3  = mem[rd_ptr].funct3;
   assign out_funct7  = mem[rd_ptr].funct7;
   assign out_illegal = mem[rd_ptr].illegal;

endmodule

// File: tb/tb_gelato_decode.sv
// tb/tb_gelato_decode.sv - randomized and directed bench for gelato_decode
module tb_gelato_decode;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_warp;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_warp;
   logic [31:0] out_pc;
   logic [6:0]  out_opcode;
   logic [4:0]  out_rd, out_rs1, out_rs2, out_rs3;
   logic [31:0] out_imm;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic        out_illegal;

   gelato_decode dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_warp(in_warp), .in_pc(in_pc), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_warp(out_warp), .out_pc(out_pc), .out_opcode(out_opcode),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
      .out_imm(out_imm), .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned warp, pc, opc, rd, rs1, rs2, rs3, imm, f3, f7, ill;
   } rec_t;

   rec_t q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference decode: classify the format, then pull fields by the ISA rules
   function automatic rec_t ref_decode(input int unsigned warp, input int unsigned pc,
                                       input logic [31:0] i);
      rec_t r;
      byte  fmt;
      r = '{default: 0};
      r.warp = warp;
      r.pc   = pc;
      r.opc  = i[6:0];
      case (i[6:0])
         7'h03, 7'h07, 7'h13, 7'h67, 7'h73: fmt = "I";
         7'h23, 7'h27:                      fmt = "S";
         7'h63:                             fmt = "B";
         7'h37, 7'h17:                      fmt = "U";
         7'h6F:                             fmt = "J";
         7'h33, 7'h53:                      fmt = "R";
         7'h43, 7'h47, 7'h4B, 7'h4F:        fmt = "4";
         default:                           fmt = "X";
      endcase
      if (fmt inside {"I", "R", "4", "U", "J"}) r.rd  = i[11:7];
      if (fmt inside {"I", "S", "B", "R", "4"}) begin
         r.rs1 = i[19:15];
         r.f3  = i[14:12];
      end
      if (fmt inside {"S", "B", "R", "4"}) r.rs2 = i[24:20];
      case (fmt)
         "I": r.imm = int'($signed(i[31:20]));
         "S": r.imm = int'($signed({i[31:25], i[11:7]}));
         "B": r.imm = int'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
         "U": r.imm = i & 32'hFFFF_F000;
         "J": r.imm = int'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
         "R": r.f7  = i[31:25];
         "4": begin
            r.rs3 = i[31:27];
            r.f7  = i[26:25];
         end
         default: r.ill = 1;
      endcase
      return r;
   endfunction

   task automatic check_outputs();
      check_val("out_valid", out_valid, q.size() != 0);
      check_val("in_ready", in_ready, q.size() != 2);
      if (q.size() != 0) begin
         check_val("warp", out_warp, q[0].warp);
         check_val("pc", out_pc, q[0].pc);
         check_val("opcode", out_opcode, q[0].opc);
         check_val("rd", out_rd, q[0].rd);
         check_val("rs1", out_rs1, q[0].rs1);
         check_val("rs2", out_rs2, q[0].rs2);
         check_val("rs3", out_rs3, q[0].rs3);
         check_val("imm", out_imm, q[0].imm);
         check_val("funct3", out_funct3, q[0].f3);
         check_val("funct7", out_funct7, q[0].f7);
         check_val("illegal", out_illegal, q[0].ill);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_valid"}, out_valid, 0);
      check_val({tag, "_ready"}, in_ready, 1);
      check_val({tag, "_data"},
                {out_warp, out_opcode, out_rd, out_rs1, out_rs2, out_rs3, out_funct3} |
                out_pc | out_imm | {out_funct7, out_illegal}, 0);
   endtask

   // Drive one cycle from just after a falling edge, advance the model at the
   // rising edge, then check at the following falling edge.
   task automatic step(input logic iv, input logic [4:0] w, input logic [31:0] pc,
                       input logic [31:0] inst, input logic ordy, input logic fl);
      bit can_push;
      in_valid  = iv;
      in_warp   = w;
      in_pc     = pc;
      in_inst   = inst;
      out_ready = ordy;
      flush     = fl;
      can_push  = (q.size() != 2);
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (q.size() != 0 && ordy) void'(q.pop_front());
         if (iv && can_push) q.push_back(ref_decode(w, pc, inst));
      end
      @(negedge clk);
      check_outputs();
   endtask

   logic [6:0] legal_ops [20] = '{7'h03, 7'h07, 7'h13, 7'h67, 7'h73, 7'h23, 7'h27,
                                  7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h53, 7'h43,
                                  7'h47, 7'h4B, 7'h4F, 7'h13, 7'h33, 7'h63};

   initial begin
      logic [31:0] w;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_warp = '0; in_pc = '0; in_inst = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs();

      // addi x1,x0,5
      step(1, 5'd3, 32'h100, 32'h0050_0093, 1, 0);
      check_val("addi_opc", out_opcode, 32'h13);
      check_val("addi_rd", out_rd, 1);
      check_val("addi_imm", out_imm, 5);
      check_val("addi_warp", out_warp, 3);
      check_val("addi_pc", out_pc, 32'h100);
      // sw x2,-4(x1) then beq x0,x0,-8
      step(1, 5'd1, 32'h104, 32'hFE20_AE23, 1, 0);
      check_val("sw_rs1", out_rs1, 1);
      check_val("sw_rs2", out_rs2, 2);
      check_val("sw_f3", out_funct3, 2);
      check_val("sw_imm", out_imm, 32'hFFFF_FFFC);
      step(1, 5'd1, 32'h108, 32'hFE00_0CE3, 1, 0);
      check_val("beq_imm", out_imm, 32'hFFFF_FFF8);
      check_val("beq_rd", out_rd, 0);
      step(0, 0, 0, 0, 1, 0);

      // Backpressure: third word held at the source until space frees up
      step(1, 5'd4, 32'h200, 32'h0010_0113, 0, 0);
      step(1, 5'd5, 32'h204, 32'h0020_8233, 0, 0);
      check_val("bp_full", in_ready, 0);
      step(1, 5'd6, 32'h208, 32'h1234_50B7, 0, 0);
      step(1, 5'd6, 32'h208, 32'h1234_50B7, 1, 0);
      step(1, 5'd6, 32'h208, 32'h1234_50B7, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      check_val("bp_drained", out_valid, 0);

      // Steady push+pop with one entry resident; pointers wrap every cycle
      step(1, 5'd7, 32'h300, 32'h0000_006F, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(1, 5'(i), 32'h304 + 32'(i * 4), 32'h0010_0093 + 32'(i << 7), 1, 0);
         check_val("pp_ready", in_ready, 1);
      end
      step(0, 0, 0, 0, 1, 0);

      // Illegal opcode, then flush while full with a live input
      step(1, 5'd9, 32'h400, 32'h0000_007F, 0, 0);
      check_val("ill_flag", out_illegal, 1);
      check_val("ill_opc", out_opcode, 32'h7F);
      check_val("ill_imm", out_imm, 0);
      step(1, 5'd9, 32'h404, 32'h0050_0093, 0, 0);
      step(1, 5'd9, 32'h408, 32'h0060_0093, 1, 1);
      check_val("flush_empty", out_valid, 0);
      check_val("flush_ready", in_ready, 1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         w = $urandom;
         if ($urandom_range(7) != 0) w[6:0] = legal_ops[$urandom_range(19)];
         step($urandom_range(9) < 7, 5'($urandom), $urandom, w,
              $urandom_range(9) < 6, $urandom_range(39) == 0);
      end

      // Reset mid-stream with both entries occupied
      step(1, 5'd2, 32'h500, 32'h0000_0013, 0, 0);
      step(1, 5'd2, 32'h504, 32'h0000_0033, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midreset");
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 5'd1, 32'h600, 32'h0050_0093, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
